rgb_fade_sequencer: RTL
=======================

// Module: rgb_fade_sequencer
// PURPOSE
//  Upstream colour source for the 3-channel RGB PWM stage on the expansion board.
//  Walks a fixed 8-entry colour palette and fades each channel linearly toward the next colour.
//  Holds each colour for a programmable time, then moves on.
//  Presents registered 8-bit duty values plus an update strobe; the PWM stage consumes them directly.
// PARAMETERS
//  STEP_DIV    50000  clk cycles per fade/hold tick (1 kHz at 50 MHz); legal range >=2
//  HOLD_STEPS  256    ticks spent in HOLD per colour; legal range >=1
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  reset_n      in   1  asynchronous, active-low reset
//  enable       in   1  level; 1 = run sequence, 0 = freeze outputs and go IDLE
//  skip         in   1  single-cycle pulse; abandon current colour, start fading to next
//  duty_r       out  8  red duty to PWM stage (0 = off, 255 = max)
//  duty_g       out  8  green duty
//  duty_b       out  8  blue duty
//  duty_valid   out  1  one-cycle pulse, high in the same cycle new duty values first appear
//  palette_idx  out  3  index of current target colour
//  state        out  2  00 IDLE, 01 FADE, 10 HOLD (11 unused)
// BEHAVIOUR
//  Reset (reset_n=0, async): duty_* = 0, duty_valid = 0, palette_idx = 0, state = IDLE.
//    Prescaler and hold counter cleared. All outputs are registered.
//  Palette (R,G,B): 0 FF0000, 1 FFFF00, 2 00FF00, 3 00FFFF,
//    4 0000FF, 5 FF00FF, 6 FFFFFF, 7 000000. Target = palette[palette_idx].
//  Prescaler: counts 0..STEP_DIV-1 while state != IDLE.
//    tick = 1 for one cycle when count == STEP_DIV-1; count then wraps to 0.
//    Forced to 0 in IDLE.
//  IDLE: entered on reset or whenever enable=0 (next edge, from any state).
//    duty_* hold their last values; duty_valid = 0.
//    enable=1 -> FADE next edge with palette_idx unchanged (resume, not restart).
//  FADE: on tick, per channel: cur<tgt -> cur+1; cur>tgt -> cur-1; else unchanged.
//    No wrap: arithmetic stays within 0..255 by construction.
//    If no channel differs from target at a tick -> HOLD, hold counter = 0, no duty change.
//    So a full 0->255 fade takes 255 stepping ticks plus 1 detection tick.
//  HOLD: on tick, hold counter++.
//    At a tick with hold counter == HOLD_STEPS-1 -> palette_idx = idx+1 (7 wraps to 0), FADE.
//  duty_valid: 1 in exactly the cycles where at least one duty_* changed on the preceding edge.
//    Never asserted in IDLE or HOLD.
//  skip (FADE or HOLD, enable=1): next edge palette_idx++ (wrap 7->0), state FADE,
//    hold counter 0, prescaler 0.
//    Fade continues from current duty values (no jump).
//  skip in IDLE or with enable=0: ignored.
//  Priority same cycle: enable=0 > skip > tick.
//    skip coincident with tick: step not applied, no duty_valid.
//  Mid-operation reset: immediate return to reset values, regardless of state.
// TESTING  (bench uses STEP_DIV=4, HOLD_STEPS=3)
//  Reset, enable=1 -> state FADE.
//    duty_r rises 1 per 4 clks, duty_valid pulses each step, duty_g=duty_b=0.
//    duty_r=255 after 255 ticks; HOLD one tick later.
//  Hold exit: after 3 HOLD ticks -> palette_idx=1, FADE.
//    duty_g ramps 0->255 while duty_r stays 255.
//  Wrap: run to idx 7 (fade to 000000), then hold.
//    palette_idx returns to 0, red ramps up from 0.
//  Skip at duty_r=100 in first FADE -> palette_idx=1 next edge.
//    duty_r continues 100->255 (no jump); skip coincident with tick gives no step.
//  enable=0 mid-fade at duty_r=50 -> IDLE, duty_r frozen at 50, no duty_valid.
//    enable=1 -> FADE resumes, duty_r=51 one tick later.
//  Assert reset_n=0 during HOLD at idx 3.
//    All outputs 0, palette_idx 0, state IDLE, asynchronously (before next clk edge).

Source files
------------

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer
// Colour source for the 3-channel RGB PWM stage. Walks a fixed 8-entry
// palette, fading each channel one LSB per tick toward the next colour,
// holding each colour for HOLD_STEPS ticks before moving on. All outputs
// are registered; duty_valid flags the cycle in which new duty values
// first appear.

module rgb_fade_sequencer #(
    parameter int unsigned STEP_DIV   = 50000,  // clk cycles per tick, >= 2
    parameter int unsigned HOLD_STEPS = 256     // ticks per colour hold, >= 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       skip,
    output logic [7:0] duty_r,
    output logic [7:0] duty_g,
    output logic [7:0] duty_b,
    output logic       duty_valid,
    output logic [2:0] palette_idx,
    output logic [1:0] state
);

    // ------------------------------------------------------------------
    // Local parameters and types
    // ------------------------------------------------------------------
    localparam int unsigned CNT_W  = (STEP_DIV > 32'd1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_STEPS + 32'd1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STEP_DIV - 32'd1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FADE = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Fixed colour palette, packed as {R, G, B}.
    function automatic logic [23:0] palette_rgb(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = 24'hFF0000;
            3'd1:    rgb = 24'hFFFF00;
            3'd2:    rgb = 24'h00FF00;
            3'd3:    rgb = 24'h00FFFF;
            3'd4:    rgb = 24'h0000FF;
            3'd5:    rgb = 24'hFF00FF;
            3'd6:    rgb = 24'hFFFFFF;
            3'd7:    rgb = 24'h000000;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

    // Move one channel one LSB toward its target; never wraps because
    // the step is only taken when the target lies strictly beyond cur.
    function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                               input logic [7:0] tgt);
        logic [7:0] nxt;
        if (cur < tgt) begin
            nxt = cur + 8'd1;
        end else if (cur > tgt) begin
            nxt = cur - 8'd1;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        duty_r_q, duty_r_d;
    logic [7:0]        duty_g_q, duty_g_d;
    logic [7:0]        duty_b_q, duty_b_d;
    logic              valid_q, valid_d;

    // ------------------------------------------------------------------
    // Decoded control signals
    // ------------------------------------------------------------------
    logic        run_s;        // sequencer active this cycle
    logic        skip_s;       // skip request that will be honoured
    logic        tick_s;       // prescaler terminal count
    logic        hold_done_s;  // last hold tick of the current colour
    logic        at_tgt_s;     // all channels equal the target colour
    logic [23:0] tgt_s;
    logic [7:0]  tgt_r_s, tgt_g_s, tgt_b_s;

    // Decode target colour, tick and qualified requests.
    always_comb begin
        tgt_s       = palette_rgb(idx_q);
        tgt_r_s     = tgt_s[23:16];
        tgt_g_s     = tgt_s[15:8];
        tgt_b_s     = tgt_s[7:0];
        run_s       = enable && (state_q != ST_IDLE);
        skip_s      = run_s && skip;
        tick_s      = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
        hold_done_s = (hold_q == HOLD_LAST);
        at_tgt_s    = (duty_r_q == tgt_r_s) &&
                      (duty_g_q == tgt_g_s) &&
                      (duty_b_q == tgt_b_s);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; enable=0 wins over skip, skip over tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_FADE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FADE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (skip_s) begin
                    state_d = ST_FADE;
                end else if (tick_s && at_tgt_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_FADE;
                end
            end
            ST_HOLD: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (skip_s) begin
                    state_d = ST_FADE;
                end else if (tick_s && hold_done_s) begin
                    state_d = ST_FADE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output / datapath logic: prescaler, hold counter, palette index, duties.
    always_comb begin
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        duty_r_d = duty_r_q;
        duty_g_d = duty_g_q;
        duty_b_d = duty_b_q;
        valid_d  = 1'b0;

        if (!run_s) begin
            // IDLE or leaving to IDLE: prescaler parked, duties frozen.
            cnt_d = '0;
        end else if (skip_s) begin
            // Abandon the current colour; the fade restarts from where
            // the duties are now, on a fresh prescaler period.
            cnt_d  = '0;
            hold_d = '0;
            idx_d  = idx_q + 3'd1;
        end else begin
            if (tick_s) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            case (state_q)
                ST_FADE: begin
                    if (tick_s && at_tgt_s) begin
                        // Detection tick: no duty change, start the hold.
                        hold_d = '0;
                    end else if (tick_s) begin
                        duty_r_d = step_toward(duty_r_q, tgt_r_s);
                        duty_g_d = step_toward(duty_g_q, tgt_g_s);
                        duty_b_d = step_toward(duty_b_q, tgt_b_s);
                        valid_d  = 1'b1;
                    end else begin
                        hold_d = hold_q;
                    end
                end
                ST_HOLD: begin
                    if (tick_s && hold_done_s) begin
                        idx_d  = idx_q + 3'd1;
                        hold_d = '0;
                    end else if (tick_s) begin
                        hold_d = hold_q + {{(HOLD_W-1){1'b0}}, 1'b1};
                    end else begin
                        hold_d = hold_q;
                    end
                end
                default: begin
                    hold_d = hold_q;
                end
            endcase
        end
    end

    // Datapath registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            hold_q   <= '0;
            idx_q    <= 3'd0;
            duty_r_q <= 8'd0;
            duty_g_q <= 8'd0;
            duty_b_q <= 8'd0;
            valid_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            duty_r_q <= duty_r_d;
            duty_g_q <= duty_g_d;
            duty_b_q <= duty_b_d;
            valid_q  <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Output connections
    // ------------------------------------------------------------------
    assign duty_r      = duty_r_q;
    assign duty_g      = duty_g_q;
    assign duty_b      = duty_b_q;
    assign duty_valid  = valid_q;
    assign palette_idx = idx_q;
    assign state       = state_q;

endmodule
